// File: rtl/pixel_window_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pixel_window_gen
// Brief    : Converts a raster-order pixel stream into every valid (unpadded)
//            K x K window, emitted as a flat KERNEL_SIZE-pixel vector with the
//            window's top-left row/column and a last-window-of-frame flag.
//            K-1 image lines are buffered internally; one output register
//            stage with a combinational ready path.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_window_gen #(
    parameter int BIT_WIDTH   = 8,
    parameter int K           = 3,
    parameter int KERNEL_SIZE = K * K,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sof,
    input  logic [BIT_WIDTH-1:0]              in_pixel,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [KERNEL_SIZE*BIT_WIDTH-1:0]  out_window,
    output logic [$clog2(IMG_H)-1:0]          out_row,
    output logic [$clog2(IMG_W)-1:0]          out_col,
    output logic                              out_last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Last column/row of the image and the first position that completes a window
    localparam logic [XW-1:0] C_X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] C_Y_MAX  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] C_X_EDGE = XW'(K - 1);
    localparam logic [YW-1:0] C_Y_EDGE = YW'(K - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XW-1:0]                     x_q, x_d;
    logic [YW-1:0]                     y_q, y_d;
    logic [BIT_WIDTH-1:0]              window_q [K][K];
    logic [BIT_WIDTH-1:0]              window_d [K][K];
    // linebuf_q[0] holds the most recent line, linebuf_q[K-2] the oldest
    logic [BIT_WIDTH-1:0]              linebuf_q [K-1][IMG_W];
    logic [BIT_WIDTH-1:0]              linebuf_d [K-1];

    logic                              out_valid_q, out_valid_d;
    logic [KERNEL_SIZE*BIT_WIDTH-1:0]  out_window_q, out_window_d;
    logic [YW-1:0]                     out_row_q, out_row_d;
    logic [XW-1:0]                     out_col_q, out_col_d;
    logic                              out_last_q, out_last_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                              accept;
    logic                              emit;
    logic [XW-1:0]                     cur_x;
    logic [YW-1:0]                     cur_y;
    logic [BIT_WIDTH-1:0]              col_new [K];

    // A stalled output window blocks new input so nothing is overwritten
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Position of the pixel being accepted; SOF forces (0,0) and resyncs counters
    always_comb begin
        cur_x = in_sof ? '0 : x_q;
        cur_y = in_sof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (accept) begin
            if (cur_x == C_X_MAX) begin
                x_d = '0;
                y_d = (cur_y == C_Y_MAX) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    // New right-hand window column: oldest buffered line on top, live pixel at bottom
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            col_new[r] = linebuf_q[K-2-r][cur_x];
        end
        col_new[K-1] = in_pixel;
    end

    // Column of data to write back into the line buffers (each line moves up one)
    always_comb begin
        linebuf_d[0] = in_pixel;
        for (int r = 1; r < K - 1; r++) begin
            linebuf_d[r] = linebuf_q[r-1][cur_x];
        end
    end

    // Window shift: every row moves one column left, new column enters on the right
    always_comb begin
        window_d = window_q;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    window_d[r][c] = window_q[r][c+1];
                end
                window_d[r][K-1] = col_new[r];
            end
        end
    end

    // A window is complete once the accepted pixel is at least K-1 rows and columns in
    assign emit = accept && (cur_x >= C_X_EDGE) && (cur_y >= C_Y_EDGE);

    // Output stage: load on emit, hold while stalled, drop valid once taken
    always_comb begin
        out_valid_d  = emit || (out_valid_q && !out_ready);
        out_window_d = out_window_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;
        if (emit) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    out_window_d[(r*K+c)*BIT_WIDTH +: BIT_WIDTH] = window_d[r][c];
                end
            end
            out_row_d  = cur_y - C_Y_EDGE;
            out_col_d  = cur_x - C_X_EDGE;
            out_last_d = (cur_x == C_X_MAX) && (cur_y == C_Y_MAX);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Counters, window array and output stage with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    window_q[r][c] <= '0;
                end
            end
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
            window_q     <= window_d;
        end
    end

    // Line buffers need no reset: rows younger than K-1 lines are never emitted
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 1; r++) begin
                linebuf_q[r][cur_x] <= linebuf_d[r];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;

endmodule
`default_nettype wire

// File: doc/pixel_window_gen.md
Name: pixel_window_gen

Overview:
Upstream feeder for binarization_input. Takes a raster-order stream of BIT_WIDTH-bit pixels, one pixel per handshake. Buffers K-1 image lines internally and emits every valid (unpadded) K x K window as a flat KERNEL_SIZE-pixel vector. Output format is `[KERNEL_SIZE-1:0][BIT_WIDTH-1:0]`, which binarization_input consumes directly as its pixel_in.

Parameters:
BIT_WIDTH, 8, pixel width in bits
K, 3, kernel edge length (K >= 2)
KERNEL_SIZE, K*K, pixels per window; must equal the binarization_input KERNEL_SIZE
IMG_W, 28, image width in pixels (IMG_W >= K)
IMG_H, 28, image height in pixels (IMG_H >= K)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_pixel is valid this cycle
in_ready  output  1  block accepts in_pixel this cycle
in_sof  input  1  start of frame; qualified by in_valid && in_ready
in_pixel  input  BIT_WIDTH  raster-order pixel, unsigned
out_valid  output  1  out_window holds a valid window
out_ready  input  1  downstream accepts the window
out_window  output  KERNEL_SIZE*BIT_WIDTH  packed window; element r*K+c = pixel (row0+r, col0+c); element 0 is top-left
out_row  output  $clog2(IMG_H)  row0 of the emitted window
out_col  output  $clog2(IMG_W)  col0 of the emitted window
out_last  output  1  emitted window is the final window of the frame

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_last=0, out_window=0, out_row=0, out_col=0.
  - Row/column counters cleared to 0.
  - in_ready=1 from the first cycle after rst_n rises.
  - Line-buffer contents are don't-care, so no clear is required.
- Input acceptance:
  - A pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register stage, combinational).
- Counters:
  - x and y give the position of the accepted pixel.
  - x wraps IMG_W-1 -> 0 and increments y.
  - y wraps IMG_H-1 -> 0, so back-to-back frames need no gap.
- Start of frame:
  - An accepted pixel with in_sof=1 is position (0,0) regardless of the counters.
  - Counters continue from there.
- Line buffers:
  - K-1 rows of IMG_W entries.
  - Written at column x on each accepted pixel, shifting row data up one line.
- Window register:
  - K x K pixel array.
  - On each accepted pixel, every row shifts one column left.
  - The new right column is {linebuf[K-2][x] .. linebuf[0][x], in_pixel}, top to bottom.
- Emit condition:
  - An accepted pixel at (y,x) with y >= K-1 and x >= K-1 completes a window.
  - On the next cycle: out_valid=1, out_row=y-K+1, out_col=x-K+1.
  - out_last=1 iff (y,x) = (IMG_H-1, IMG_W-1).
- Latency: 1 cycle from the accepting edge to out_valid.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- Windows never span a row wrap, because the x >= K-1 check guarantees this.
- Backpressure:
  - While out_valid && !out_ready, out_window, out_row, out_col and out_last hold stable.
  - in_ready=0 during this, so no pixel is lost.
- Handshake completion:
  - out_valid drops after out_valid && out_ready unless a new window is produced on the same edge.
  - Simultaneous accept-in and accept-out loads the new window, with no bubble.
- Non-emitting pixels: an accepted pixel that does not complete a window clears out_valid if the old window was taken, else leaves it held.
- Frame data isolation: windows only emit at y >= K-1, so stale line-buffer data from a previous frame or reset never appears in an output.
- Reset mid-frame: everything above returns to reset state immediately, and the next accepted pixel is treated as (0,0).
- Arithmetic: pixels pass through unmodified; no padding, scaling or sign handling.

Test Plan:
1. IMG_W=IMG_H=4, K=3; stream pixel = 4y+x with out_ready=1 -> 4 windows.
   - First window is {0,1,2,4,5,6,8,9,10}, out_row=0, out_col=0, out_valid one cycle after pixel 10 is accepted.
   - Last window is {5,6,7,9,10,11,13,14,15} with out_last=1.
2. Same stream, out_ready held low 5 cycles while the first window is valid.
   - out_window stays {0,1,..,10} and in_ready=0 for all 5 cycles.
   - The next pixel (11) is accepted on the cycle out_ready rises.
   - Window count is still 4.
3. Two frames back-to-back with in_sof on each first pixel, frame 2 pixels = 100+4y+x.
   - 8 windows total.
   - Frame 2's first window is {100,101,102,104,105,106,108,109,110}.
   - No window mixes the two frames.
4. rst_n pulsed low after 7 pixels of a frame.
   - out_valid=0 immediately.
   - A fresh 16-pixel frame then gives exactly the 4 windows of test 1.
5. in_valid toggled randomly, out_ready=1, pixel = 4y+x.
   - Same 4 windows in order (0,0),(0,1),(1,0),(1,1), with correct contents.
6. in_sof asserted on the 6th pixel of a frame.
   - Counters resync: that pixel is treated as (0,0).
   - The next 16 pixels produce exactly 4 correct windows.
